spiker_spike_collector: RTL and testbench
=========================================

# spiker_spike_collector

Upstream stage of the register-file writer that captures network results. It accepts output-spike events from the spiking core as a valid/ready stream of neuron indices and accumulates them over an inference window of a programmed number of timesteps. At the end of the window it presents a DATA_WIDTH-wide fired-neuron vector on `data_out_o` with a one-cycle `sample_o` strobe, which the writer loads into the `spikes_result` registers.

## Interface
- `DATA_WIDTH`, 800: number of output neurons; width of the result vector.
- `IDX_WIDTH`, `$clog2(DATA_WIDTH)`: neuron index width. Derived; not overridden.
- `STEP_WIDTH`, 16: width of the timestep counter and of `n_steps_i`.
- `CNT_WIDTH`, 16: width of the spike counter.

Ports:
- `clk_i` in 1: clock; all logic on the rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `start_i` in 1: one-cycle pulse; opens an inference window. Honoured only in IDLE.
- `n_steps_i` in STEP_WIDTH: timesteps per window. Sampled on the accepted `start_i`.
- `step_done_i` in 1: one-cycle pulse from the core at the end of each timestep.
- `spike_valid_i` in 1: a spike event is present.
- `spike_idx_i` in IDX_WIDTH: index of the neuron that fired.
- `spike_ready_o` out 1: the collector accepts the event.
- `data_out_o` out DATA_WIDTH: bit i = 1 if neuron i fired at least once in the last completed window.
- `sample_o` out 1: one-cycle strobe; `data_out_o` is valid in this cycle.
- `spike_cnt_o` out CNT_WIDTH: accepted in-range spikes in the last completed window. Saturates at all-ones.
- `busy_o` out 1: high in COLLECT and DONE.
- `err_o` out 1: sticky flag. Set by any accepted index ≥ DATA_WIDTH. Cleared by an accepted `start_i` or by reset.

## Operation
- FSM states: IDLE, COLLECT, DONE.
- **IDLE**
  - `spike_ready_o` = 0.
  - On `start_i`:
    - clear the accumulator `acc`, the step counter and the running spike count;
    - clear `err_o`;
    - latch `n_steps_i`.
  - Next state: DONE if the latched value is 0, otherwise COLLECT.
- **COLLECT**
  - `spike_ready_o` = 1 in every cycle of this state.
  - Handshake (valid & ready), index < DATA_WIDTH:
    - set `acc[idx]`; repeated indices are idempotent;
    - increment the running count, saturating.
  - Handshake, index ≥ DATA_WIDTH: set `err_o`; `acc` and the count are unchanged.
  - On `step_done_i`, increment the step counter. When the incremented value equals the latched step count, go to DONE.
  - A spike accepted in the same cycle as the final `step_done_i` belongs to the window and is included.
  - `start_i` is ignored.
- **DONE** (exactly one cycle)
  - `data_out_o` <= `acc`.
  - `spike_cnt_o` <= running count.
  - `sample_o` = 1.
  - Next state: IDLE.
  - `start_i` is ignored.
- `data_out_o` and `spike_cnt_o` hold their values until the next DONE.
- `step_done_i` in IDLE or DONE is ignored.
- The step comparison is exact equality on STEP_WIDTH bits; the counter cannot wrap, because it leaves COLLECT on the match.

## Timing
- Reset values:
  - state = IDLE;
  - `data_out_o` = 0, `spike_cnt_o` = 0;
  - `sample_o` = 0, `spike_ready_o` = 0, `busy_o` = 0, `err_o` = 0;
  - `acc`, counters and latched step count = 0.
- Reset asserted mid-window: all of the above apply immediately (asynchronous). The partial window is discarded and no `sample_o` is issued.
- `start_i` in cycle t moves the FSM to COLLECT in cycle t+1. `spike_ready_o` = 1 from t+1.
- Final `step_done_i` in cycle t:
  - DONE in cycle t+1: `sample_o` = 1 and `data_out_o` / `spike_cnt_o` already show the new values (registered at the t+1 edge);
  - IDLE in cycle t+2.
- `n_steps_i` = 0: `start_i` in cycle t gives `sample_o` in t+1, with `data_out_o` = 0 and `spike_cnt_o` = 0.
- Back-to-back windows: a new `start_i` is honoured no earlier than the IDLE cycle after DONE.
- Throughput in COLLECT: one spike per cycle. No backpressure within the window.

## Test plan
- **Reset:** assert `rst_i` asynchronously between clock edges.
  - Required: all outputs 0 and `spike_ready_o` = 0 before the next edge.
- **Basic window:** `n_steps` = 3; spikes 5, 799, 0 in step 1; spike 5 again in step 3.
  - Required: `sample_o` one cycle after the third `step_done_i`.
  - Required: `data_out_o` has only bits 0, 5 and 799 set; `spike_cnt_o` = 4.
- **Same-cycle event:** spike idx 42 in the same cycle as the final `step_done_i`.
  - Required: bit 42 set in `data_out_o`.
- **Out-of-range index:** idx 800 and idx 1023 during a window.
  - Required: `err_o` = 1 from the cycle after the first one; `data_out_o` unaffected; count excludes them.
  - Required: the next `start_i` clears `err_o`.
- **Zero steps and ignored start:**
  - `n_steps` = 0: `sample_o` at t+1 with an all-zero vector.
  - `start_i` during COLLECT: no effect on the counters; `sample_o` occurs only at the programmed step count.
- **Mid-window reset, then saturation:**
  - `rst_i` after 2 of 4 steps: no `sample_o`, outputs 0.
  - New window with 65540 accepted spikes: `spike_cnt_o` = 65535.

Source files
------------

// File: rtl/spiker_spike_collector.sv
// Spike collector: accumulates accepted output-spike indices over a programmed
// number of timesteps and publishes the fired-neuron vector with a one-cycle strobe.
module spiker_spike_collector #(
    parameter int DATA_WIDTH = 800,
    parameter int IDX_WIDTH  = $clog2(DATA_WIDTH),
    parameter int STEP_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [STEP_WIDTH-1:0] n_steps_i,
    input  logic                  step_done_i,
    input  logic                  spike_valid_i,
    input  logic [IDX_WIDTH-1:0]  spike_idx_i,
    output logic                  spike_ready_o,
    output logic [DATA_WIDTH-1:0] data_out_o,
    output logic                  sample_o,
    output logic [CNT_WIDTH-1:0]  spike_cnt_o,
    output logic                  busy_o,
    output logic                  err_o,
    output logic [1:0]            state_o
);

    // Handshake: an event transfers in any cycle where spike_valid_i and
    // spike_ready_o are both high; ready is high exactly while collecting.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [IDX_WIDTH:0] IDX_LIMIT = (IDX_WIDTH + 1)'(DATA_WIDTH);

    state_t                state_q,    state_d;
    logic [DATA_WIDTH-1:0] acc_q,      acc_d;
    logic [STEP_WIDTH-1:0] step_cnt_q, step_cnt_d;
    logic [STEP_WIDTH-1:0] n_steps_q,  n_steps_d;
    logic [CNT_WIDTH-1:0]  run_cnt_q,  run_cnt_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [CNT_WIDTH-1:0]  spike_cnt_q, spike_cnt_d;
    logic                  err_q,      err_d;
    logic                  accept;
    logic                  in_range;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        step_cnt_d  = step_cnt_q;
        n_steps_d   = n_steps_q;
        run_cnt_d   = run_cnt_q;
        data_out_d  = data_out_q;
        spike_cnt_d = spike_cnt_q;
        err_d       = err_q;
        accept      = (state_q == S_COLLECT) && spike_valid_i;
        in_range    = {1'b0, spike_idx_i} < IDX_LIMIT;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    acc_d      = '0;
                    step_cnt_d = '0;
                    run_cnt_d  = '0;
                    err_d      = 1'b0;
                    n_steps_d  = n_steps_i;
                    state_d    = (n_steps_i == '0) ? S_DONE : S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    if (in_range) begin
                        acc_d[spike_idx_i] = 1'b1;
                        if (run_cnt_q != '1) begin
                            run_cnt_d = run_cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                if (step_done_i) begin
                    step_cnt_d = step_cnt_q + STEP_WIDTH'(1);
                    if (step_cnt_d == n_steps_q) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results are registered on the edge that enters DONE so they are
        // already valid while sample_o is high, including a same-cycle spike.
        if (state_d == S_DONE) begin
            data_out_d  = acc_d;
            spike_cnt_d = run_cnt_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            step_cnt_q  <= '0;
            n_steps_q   <= '0;
            run_cnt_q   <= '0;
            data_out_q  <= '0;
            spike_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            step_cnt_q  <= step_cnt_d;
            n_steps_q   <= n_steps_d;
            run_cnt_q   <= run_cnt_d;
            data_out_q  <= data_out_d;
            spike_cnt_q <= spike_cnt_d;
            err_q       <= err_d;
        end
    end

    assign spike_ready_o = (state_q == S_COLLECT);
    assign sample_o      = (state_q == S_DONE);
    assign busy_o        = (state_q != S_IDLE);
    assign data_out_o    = data_out_q;
    assign spike_cnt_o   = spike_cnt_q;
    assign err_o         = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_spiker_spike_collector.sv
// Directed bench for spiker_spike_collector: hand-computed windows checked with
// immediate assertions, ending in a single summary line.
module tb_spiker_spike_collector;

    localparam int DW = 800;
    localparam int IW = $clog2(DW);
    localparam int SW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [SW-1:0] n_steps_i;
    logic          step_done_i;
    logic          spike_valid_i;
    logic [IW-1:0] spike_idx_i;
    logic          spike_ready_o;
    logic [DW-1:0] data_out_o;
    logic          sample_o;
    logic [CW-1:0] spike_cnt_o;
    logic          busy_o;
    logic          err_o;
    logic [1:0]    state_o;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_v;

    spiker_spike_collector dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .n_steps_i     (n_steps_i),
        .step_done_i   (step_done_i),
        .spike_valid_i (spike_valid_i),
        .spike_idx_i   (spike_idx_i),
        .spike_ready_o (spike_ready_o),
        .data_out_o    (data_out_o),
        .sample_o      (sample_o),
        .spike_cnt_o   (spike_cnt_o),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, then return to idle levels.
    task automatic drive(input logic st, input logic [SW-1:0] n, input logic v,
                         input logic [IW-1:0] idx, input logic sd);
        start_i       = st;
        n_steps_i     = n;
        spike_valid_i = v;
        spike_idx_i   = idx;
        step_done_i   = sd;
        tick();
        start_i       = 1'b0;
        spike_valid_i = 1'b0;
        step_done_i   = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; n_steps_i = '0; step_done_i = 1'b0;
        spike_valid_i = 1'b0; spike_idx_i = '0;
        #3;
        check("rst_sample", 32'(sample_o), 0);
        check("rst_ready", 32'(spike_ready_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_cnt", 32'(spike_cnt_o), 0);
        check_vec("rst_data", data_out_o, '0);
        tick(); tick();
        rst_i = 1'b0;
        tick();

        // Basic window: 3 steps, spikes 5,799,0 then 5 again
        drive(1'b1, 16'd3, 1'b0, '0, 1'b0);
        check("basic_ready", 32'(spike_ready_o), 1);
        check("basic_busy", 32'(busy_o), 1);
        drive(1'b0, '0, 1'b1, 10'd5, 1'b0);
        drive(1'b0, '0, 1'b1, 10'd799, 1'b0);
        drive(1'b0, '0, 1'b1, 10'd0, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("basic_no_early_sample", 32'(sample_o), 0);
        drive(1'b0, '0, 1'b1, 10'd5, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        exp_v = '0; exp_v[0] = 1'b1; exp_v[5] = 1'b1; exp_v[799] = 1'b1;
        check("basic_sample", 32'(sample_o), 1);
        check_vec("basic_data", data_out_o, exp_v);
        check("basic_cnt", 32'(spike_cnt_o), 4);
        tick();
        check("basic_sample_1cyc", 32'(sample_o), 0);
        check("basic_idle_busy", 32'(busy_o), 0);
        check_vec("basic_data_hold", data_out_o, exp_v);

        // Spike in the same cycle as the final step_done
        drive(1'b1, 16'd1, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, 10'd42, 1'b1);
        exp_v = '0; exp_v[42] = 1'b1;
        check("same_sample", 32'(sample_o), 1);
        check_vec("same_data", data_out_o, exp_v);
        check("same_cnt", 32'(spike_cnt_o), 1);
        tick();

        // Out-of-range indices
        drive(1'b1, 16'd2, 1'b0, '0, 1'b0);
        check("oor_err_before", 32'(err_o), 0);
        drive(1'b0, '0, 1'b1, 10'd800, 1'b0);
        check("oor_err_set", 32'(err_o), 1);
        drive(1'b0, '0, 1'b1, 10'd1023, 1'b0);
        drive(1'b0, '0, 1'b1, 10'd7, 1'b0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        exp_v = '0; exp_v[7] = 1'b1;
        check("oor_sample", 32'(sample_o), 1);
        check_vec("oor_data", data_out_o, exp_v);
        check("oor_cnt", 32'(spike_cnt_o), 1);
        check("oor_err_sticky", 32'(err_o), 1);
        tick();

        // Zero steps: sample one cycle after start, and err cleared
        drive(1'b1, 16'd0, 1'b0, '0, 1'b0);
        check("zero_sample", 32'(sample_o), 1);
        check("zero_busy", 32'(busy_o), 1);
        check_vec("zero_data", data_out_o, '0);
        check("zero_cnt", 32'(spike_cnt_o), 0);
        check("zero_err_clr", 32'(err_o), 0);
        tick();
        check("zero_idle", 32'(sample_o), 0);

        // start_i during COLLECT and DONE is ignored
        drive(1'b1, 16'd2, 1'b0, '0, 1'b0);
        drive(1'b1, 16'd9, 1'b1, 10'd100, 1'b0);
        check("ign_busy", 32'(busy_o), 1);
        check("ign_no_sample0", 32'(sample_o), 0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("ign_no_sample1", 32'(sample_o), 0);
        drive(1'b1, 16'd9, 1'b0, '0, 1'b1);
        exp_v = '0; exp_v[100] = 1'b1;
        check("ign_sample", 32'(sample_o), 1);
        check_vec("ign_data", data_out_o, exp_v);
        check("ign_cnt", 32'(spike_cnt_o), 1);
        drive(1'b1, 16'd0, 1'b0, '0, 1'b0);
        check("ign_done_start_busy", 32'(busy_o), 0);
        tick();
        check("ign_done_start_sample", 32'(sample_o), 0);

        // Mid-window asynchronous reset after 2 of 4 steps
        drive(1'b1, 16'd4, 1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, 10'd900, 1'b0);
        check("mid_err_set", 32'(err_o), 1);
        drive(1'b0, '0, 1'b1, 10'd3, 1'b1);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        rst_i = 1'b1;
        #1;
        check("mid_rst_ready", 32'(spike_ready_o), 0);
        check("mid_rst_busy", 32'(busy_o), 0);
        check("mid_rst_err", 32'(err_o), 0);
        check("mid_rst_cnt", 32'(spike_cnt_o), 0);
        check_vec("mid_rst_data", data_out_o, '0);
        tick();
        rst_i = 1'b0;
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("mid_no_sample0", 32'(sample_o), 0);
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        check("mid_no_sample1", 32'(sample_o), 0);
        check("mid_idle_busy", 32'(busy_o), 0);

        // Saturation: 65540 accepted spikes in one step
        drive(1'b1, 16'd1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 65540; i++) begin
            drive(1'b0, '0, 1'b1, IW'(i % DW), (i == 65539));
        end
        check("sat_sample", 32'(sample_o), 1);
        check("sat_cnt", 32'(spike_cnt_o), 32'hFFFF);
        check_vec("sat_data", data_out_o, '1);
        tick();
        check("sat_idle", 32'(busy_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
